// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Holds the fetched instruction in ir, exposes ir[6:0] as opcode to the bus
// routing, and issues memory handshakes plus register-write / PC-update strobes.
// Optional build macro EXEC_SEQ_TIMEOUT_EN: when defined, FETCH and MEM give up
// after MEM_TIMEOUT cycles without ack and fault with code 2 or 3; when
// undefined they wait for ack indefinitely and no wait counter exists.
module exec_sequencer #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            fault_clr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [6:0]      opcode,
  input  logic [2:0]      wrr,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic            pc_we,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [XLEN-1:0] instret
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [2:0]      stateReg, stateNext;
  logic [1:0]      faultCodeReg, faultCodeNext;
  logic [31:0]     irReg;
  logic            rdWriteReg;
  logic [XLEN-1:0] instretReg;
  logic            waitExpired;
  logic            isMemOp;

  assign isMemOp = (irReg[6:0] == OP_LOAD) || (irReg[6:0] == OP_STORE);

`ifdef EXEC_SEQ_TIMEOUT_EN
  localparam int              CntW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] waitCntReg;

  // Without ack, this cycle is the last one allowed; ack in it still wins.
  assign waitExpired = (waitCntReg == WaitLast);

  // Wait counter: cleared on any state change, counts cycles spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCntReg <= '0;
    end else if (stateNext != stateReg) begin
      waitCntReg <= '0;
    end else if ((stateReg == FETCH) || (stateReg == MEM)) begin
      waitCntReg <= waitCntReg + CntW'(1);
    end
  end
`else
  assign waitExpired = 1'b0;
`endif

  // Next-state and fault-code selection.
  always_comb begin
    stateNext     = stateReg;
    faultCodeNext = faultCodeReg;
    case (stateReg)
      IDLE: begin
        if (run) stateNext = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          stateNext = DECODE;
        end else if (waitExpired) begin
          stateNext     = FAULT;
          faultCodeNext = 2'd2;
        end
      end
      DECODE: begin
        if (wrr == 3'b000) begin
          stateNext     = FAULT;
          faultCodeNext = 2'd1;
        end else begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        stateNext = isMemOp ? MEM : WB;
      end
      MEM: begin
        if (dmem_ack) begin
          stateNext = WB;
        end else if (waitExpired) begin
          stateNext     = FAULT;
          faultCodeNext = 2'd3;
        end
      end
      WB: begin
        stateNext = run ? FETCH : IDLE;
      end
      FAULT: begin
        if (fault_clr) begin
          stateNext     = IDLE;
          faultCodeNext = 2'd0;
        end
      end
      default: begin
        stateNext     = IDLE;
        faultCodeNext = 2'd0;
      end
    endcase
  end

  // State and sticky fault code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      faultCodeReg <= 2'd0;
    end else begin
      stateReg     <= stateNext;
      faultCodeReg <= faultCodeNext;
    end
  end

  // Instruction register loads only on an ack seen in FETCH; rd-write permission latched in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irReg      <= 32'd0;
      rdWriteReg <= 1'b0;
    end else begin
      if ((stateReg == FETCH) && imem_ack) irReg <= imem_rdata;
      if (stateReg == DECODE) rdWriteReg <= wrr[2];
    end
  end

  // Retired-instruction counter, bumps once per WB and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instretReg <= '0;
    end else if (stateReg == WB) begin
      instretReg <= instretReg + XLEN'(1);
    end
  end

  assign imem_req   = (stateReg == FETCH);
  assign dmem_req   = (stateReg == MEM);
  assign dmem_we    = (stateReg == MEM) && (irReg[6:0] == OP_STORE);
  assign reg_we     = (stateReg == WB) && rdWriteReg;
  assign pc_we      = (stateReg == WB);
  assign busy       = (stateReg != IDLE) && (stateReg != FAULT);
  assign fault      = (stateReg == FAULT);
  assign fault_code = faultCodeReg;
  assign ir         = irReg;
  assign opcode     = irReg[6:0];
  assign instret    = instretReg;

endmodule
